// File: rtl/iob_cache_axi_mem_responder.sv
// ---------------------------------------------------------------------------
// iob_cache_axi_mem_responder
//
// AXI4 slave memory model answering a cache back-end AXI master. It serves
// line-fill read bursts and write-through / write-back write bursts from an
// internal byte-enabled word array. Read and write channels run independent
// FSMs, each with at most one transaction in flight.
//
// Ports:
//   clk_i, rst_n_i              clock, asynchronous active-low reset
//   axi_aw*_i / axi_awready_o   write address channel (id, addr, len, valid)
//   axi_w*_i / axi_wready_o     write data channel (data, strb, last, valid)
//   axi_b*_o / axi_bready_i     write response channel (id, resp, valid)
//   axi_ar*_i / axi_arready_o   read address channel (id, addr, len, valid)
//   axi_r*_o / axi_rready_i     read data channel (id, data, resp, last, valid)
//
// Only full-width INCR bursts are modelled. The word index is taken from
// addr[NB_W +: MEM_ADDR_W]; higher address bits alias, and the index wraps
// modulo the array depth during a burst.
// ---------------------------------------------------------------------------
module iob_cache_axi_mem_responder #(
    parameter int AXI_ADDR_W = 24,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_ID_W   = 1,
    parameter int AXI_LEN_W  = 8,
    parameter int MEM_ADDR_W = 10,
    parameter int READ_LAT   = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    // write address
    input  logic [AXI_ID_W-1:0]     axi_awid_i,
    input  logic [AXI_ADDR_W-1:0]   axi_awaddr_i,
    input  logic [AXI_LEN_W-1:0]    axi_awlen_i,
    input  logic                    axi_awvalid_i,
    output logic                    axi_awready_o,
    // write data
    input  logic [AXI_DATA_W-1:0]   axi_wdata_i,
    input  logic [AXI_DATA_W/8-1:0] axi_wstrb_i,
    input  logic                    axi_wlast_i,
    input  logic                    axi_wvalid_i,
    output logic                    axi_wready_o,
    // write response
    output logic [AXI_ID_W-1:0]     axi_bid_o,
    output logic [1:0]              axi_bresp_o,
    output logic                    axi_bvalid_o,
    input  logic                    axi_bready_i,
    // read address
    input  logic [AXI_ID_W-1:0]     axi_arid_i,
    input  logic [AXI_ADDR_W-1:0]   axi_araddr_i,
    input  logic [AXI_LEN_W-1:0]    axi_arlen_i,
    input  logic                    axi_arvalid_i,
    output logic                    axi_arready_o,
    // read data
    output logic [AXI_ID_W-1:0]     axi_rid_o,
    output logic [AXI_DATA_W-1:0]   axi_rdata_o,
    output logic [1:0]              axi_rresp_o,
    output logic                    axi_rlast_o,
    output logic                    axi_rvalid_o,
    input  logic                    axi_rready_i
);

    localparam int NB    = AXI_DATA_W / 8;
    localparam int NB_W  = $clog2(NB);
    localparam int DEPTH = 2 ** MEM_ADDR_W;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;

    // Array is intentionally never reset: contents survive rst_n_i.
    logic [AXI_DATA_W-1:0] mem_q [DEPTH];

    // ---------------- write channel ----------------
    wstate_t               wstate_q;
    logic                  awready_q, wready_q, bvalid_q;
    logic [1:0]            bresp_q;
    logic [AXI_ID_W-1:0]   bid_q;
    logic [MEM_ADDR_W-1:0] widx_q;
    logic [AXI_LEN_W-1:0]  wlen_q, wbeat_q;

    logic w_fire, w_at_len;
    assign w_fire   = wready_q & axi_wvalid_i;
    assign w_at_len = (wbeat_q == wlen_q);

    always_ff @(posedge clk_i) begin
        if (w_fire) begin
            for (int i = 0; i < NB; i++) begin
                if (axi_wstrb_i[i]) mem_q[widx_q][i*8 +: 8] <= axi_wdata_i[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            bid_q     <= '0;
            widx_q    <= '0;
            wlen_q    <= '0;
            wbeat_q   <= '0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    if (awready_q && axi_awvalid_i) begin
                        bid_q     <= axi_awid_i;
                        widx_q    <= axi_awaddr_i[NB_W +: MEM_ADDR_W];
                        wlen_q    <= axi_awlen_i;
                        wbeat_q   <= '0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        wstate_q  <= W_DATA;
                    end else begin
                        // first cycle out of reset raises awready here
                        awready_q <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        widx_q  <= widx_q + 1'b1;
                        wbeat_q <= wbeat_q + 1'b1;
                        // burst closes on whichever comes first: wlast or the
                        // announced length; disagreement means SLVERR
                        if (axi_wlast_i || w_at_len) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bresp_q  <= (axi_wlast_i != w_at_len) ? RESP_SLVERR : RESP_OKAY;
                            wstate_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (axi_bready_i) begin
                        bvalid_q  <= 1'b0;
                        bresp_q   <= RESP_OKAY;
                        awready_q <= 1'b1;
                        wstate_q  <= W_IDLE;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    // ---------------- read channel ----------------
    rstate_t               rstate_q;
    logic                  arready_q, rvalid_q, rlast_q;
    logic [AXI_DATA_W-1:0] rdata_q;
    logic [AXI_ID_W-1:0]   rid_q;
    logic [MEM_ADDR_W-1:0] ridx_q, ridx_d;
    logic [AXI_LEN_W-1:0]  rlen_q, rbeat_q, rbeat_d;
    logic [3:0]            rlat_q;

    assign ridx_d  = ridx_q + 1'b1;
    assign rbeat_d = rbeat_q + 1'b1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
            rid_q     <= '0;
            ridx_q    <= '0;
            rlen_q    <= '0;
            rbeat_q   <= '0;
            rlat_q    <= '0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (arready_q && axi_arvalid_i) begin
                        rid_q     <= axi_arid_i;
                        ridx_q    <= axi_araddr_i[NB_W +: MEM_ADDR_W];
                        rlen_q    <= axi_arlen_i;
                        rbeat_q   <= '0;
                        rlat_q    <= '0;
                        arready_q <= 1'b0;
                        rstate_q  <= R_WAIT;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_WAIT: begin
                    // first beat becomes visible READ_LAT+1 cycles after AR
                    if (rlat_q == 4'(READ_LAT)) begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= mem_q[ridx_q];
                        rlast_q  <= (rlen_q == '0);
                        rstate_q <= R_DATA;
                    end else begin
                        rlat_q <= rlat_q + 4'd1;
                    end
                end
                R_DATA: begin
                    // outputs only move on a handshake, so they hold under stall
                    if (axi_rready_i) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            rstate_q  <= R_IDLE;
                        end else begin
                            ridx_q  <= ridx_d;
                            rbeat_q <= rbeat_d;
                            rdata_q <= mem_q[ridx_d];
                            rlast_q <= (rbeat_d == rlen_q);
                        end
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    // address bits outside the word index are don't-care (aliasing)
    logic unused_addr_bits;
    assign unused_addr_bits = ^{axi_awaddr_i, axi_araddr_i};

    assign axi_awready_o = awready_q;
    assign axi_wready_o  = wready_q;
    assign axi_bid_o     = bid_q;
    assign axi_bresp_o   = bresp_q;
    assign axi_bvalid_o  = bvalid_q;
    assign axi_arready_o = arready_q;
    assign axi_rid_o     = rid_q;
    assign axi_rdata_o   = rdata_q;
    assign axi_rresp_o   = RESP_OKAY;
    assign axi_rlast_o   = rlast_q;
    assign axi_rvalid_o  = rvalid_q;

endmodule

// File: tb/tb_iob_cache_axi_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_iob_cache_axi_mem_responder
//
// Directed self-checking bench for the AXI memory responder: bursts, byte
// strobes, index wrap, SLVERR on wlast mismatch, read latency, stalls and
// reset in the middle of a read burst. Inputs change 1 time unit after the
// rising edge; outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_iob_cache_axi_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic [0:0]  axi_awid_i, axi_bid_o, axi_arid_i, axi_rid_o;
    logic [23:0] axi_awaddr_i, axi_araddr_i;
    logic [7:0]  axi_awlen_i, axi_arlen_i;
    logic        axi_awvalid_i, axi_awready_o;
    logic [31:0] axi_wdata_i, axi_rdata_o;
    logic [3:0]  axi_wstrb_i;
    logic        axi_wlast_i, axi_wvalid_i, axi_wready_o;
    logic [1:0]  axi_bresp_o, axi_rresp_o;
    logic        axi_bvalid_o, axi_bready_i;
    logic        axi_arvalid_i, axi_arready_o;
    logic        axi_rlast_o, axi_rvalid_o, axi_rready_i;

    iob_cache_axi_mem_responder dut (
        .clk_i(clk), .rst_n_i(rst_n_i),
        .axi_awid_i(axi_awid_i), .axi_awaddr_i(axi_awaddr_i), .axi_awlen_i(axi_awlen_i),
        .axi_awvalid_i(axi_awvalid_i), .axi_awready_o(axi_awready_o),
        .axi_wdata_i(axi_wdata_i), .axi_wstrb_i(axi_wstrb_i), .axi_wlast_i(axi_wlast_i),
        .axi_wvalid_i(axi_wvalid_i), .axi_wready_o(axi_wready_o),
        .axi_bid_o(axi_bid_o), .axi_bresp_o(axi_bresp_o), .axi_bvalid_o(axi_bvalid_o),
        .axi_bready_i(axi_bready_i),
        .axi_arid_i(axi_arid_i), .axi_araddr_i(axi_araddr_i), .axi_arlen_i(axi_arlen_i),
        .axi_arvalid_i(axi_arvalid_i), .axi_arready_o(axi_arready_o),
        .axi_rid_o(axi_rid_o), .axi_rdata_o(axi_rdata_o), .axi_rresp_o(axi_rresp_o),
        .axi_rlast_o(axi_rlast_o), .axi_rvalid_o(axi_rvalid_o), .axi_rready_i(axi_rready_i)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] wbuf [16];
    logic [31:0] rbuf [16];
    logic        rlb  [16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // wl_at: beat index carrying wlast (>len means never asserted)
    task automatic axi_write(input logic [23:0] addr, input int len, input int wl_at,
                             input logic [3:0] strb, input logic id, input bit stall,
                             output logic [1:0] resp, output logic bid);
        int nb, to;
        nb = ((wl_at < len) ? wl_at : len) + 1;
        axi_awaddr_i = addr; axi_awlen_i = 8'(len); axi_awid_i = id; axi_awvalid_i = 1'b1;
        to = 0;
        while (!axi_awready_o && to < 100) begin tick(); to++; end
        chk("aw_hs", 32'(to < 100), 1);
        tick();
        axi_awvalid_i = 1'b0;
        for (int b = 0; b < nb; b++) begin
            if (stall) repeat ($urandom_range(0, 2)) tick();
            axi_wdata_i = wbuf[b]; axi_wstrb_i = strb;
            axi_wlast_i = (b == wl_at); axi_wvalid_i = 1'b1;
            to = 0;
            while (!axi_wready_o && to < 100) begin tick(); to++; end
            if (to >= 100) chk("w_hs", 0, 1);
            tick();
            axi_wvalid_i = 1'b0; axi_wlast_i = 1'b0;
        end
        chk("b_lat", 32'(axi_bvalid_o), 1);
        to = 0;
        while (!axi_bvalid_o && to < 100) begin tick(); to++; end
        resp = axi_bresp_o; bid = axi_bid_o;
        tick();
        chk("b_drop", 32'(axi_bvalid_o), 0);
    endtask

    task automatic ar_send(input logic [23:0] addr, input int len, input logic id);
        int to;
        axi_araddr_i = addr; axi_arlen_i = 8'(len); axi_arid_i = id; axi_arvalid_i = 1'b1;
        to = 0;
        while (!axi_arready_o && to < 100) begin tick(); to++; end
        chk("ar_hs", 32'(to < 100), 1);
        tick();
        axi_arvalid_i = 1'b0;
    endtask

    task automatic axi_read(input logic [23:0] addr, input int len, input logic id,
                            input bit stall, output int lat, output int cyc);
        int b;
        ar_send(addr, len, id);
        axi_rready_i = 1'b1;
        lat = 0;
        while (!axi_rvalid_o && lat < 100) begin tick(); lat++; end
        chk("rid", 32'(axi_rid_o), 32'(id));
        chk("rresp", 32'(axi_rresp_o), 0);
        b = 0; cyc = 0;
        while (b <= len && cyc < 300) begin
            if (stall) axi_rready_i = 1'($urandom_range(0, 1));
            if (axi_rvalid_o && axi_rready_i) begin
                rbuf[b] = axi_rdata_o; rlb[b] = axi_rlast_o; b++;
            end
            tick(); cyc++;
        end
        axi_rready_i = 1'b0;
        chk("r_beats", 32'(b), 32'(len + 1));
        chk("r_idle", 32'(axi_rvalid_o), 0);
        for (int i = 0; i <= len; i++) chk("rlast", 32'(rlb[i]), 32'(i == len));
    endtask

    initial begin
        logic [1:0] resp;
        logic       bid;
        int         lat, cyc;

        rst_n_i = 1'b0;
        axi_awid_i = '0; axi_awaddr_i = '0; axi_awlen_i = '0; axi_awvalid_i = 1'b0;
        axi_wdata_i = '0; axi_wstrb_i = '0; axi_wlast_i = 1'b0; axi_wvalid_i = 1'b0;
        axi_bready_i = 1'b1;
        axi_arid_i = '0; axi_araddr_i = '0; axi_arlen_i = '0; axi_arvalid_i = 1'b0;
        axi_rready_i = 1'b0;

        // reset state
        repeat (3) tick();
        chk("rst_awready", 32'(axi_awready_o), 0);
        chk("rst_arready", 32'(axi_arready_o), 0);
        chk("rst_wready",  32'(axi_wready_o), 0);
        chk("rst_bvalid",  32'(axi_bvalid_o), 0);
        chk("rst_rvalid",  32'(axi_rvalid_o), 0);
        rst_n_i = 1'b1;
        chk("rel_awready0", 32'(axi_awready_o), 0);
        tick();
        chk("rel_awready1", 32'(axi_awready_o), 1);
        chk("rel_arready1", 32'(axi_arready_o), 1);

        // 4-beat write then read back
        wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
        axi_write(24'h40, 3, 3, 4'hF, 1'b1, 1'b0, resp, bid);
        chk("t1_bresp", 32'(resp), 0);
        chk("t1_bid", 32'(bid), 1);
        axi_read(24'h40, 3, 1'b0, 1'b0, lat, cyc);
        chk("t2_lat", 32'(lat), 3);
        chk("t2_b2b", 32'(cyc), 4);
        chk("t2_d0", rbuf[0], 32'h11);
        chk("t2_d1", rbuf[1], 32'h22);
        chk("t2_d2", rbuf[2], 32'h33);
        chk("t2_d3", rbuf[3], 32'h44);

        // partial byte strobes
        wbuf[0] = 32'h11223344;
        axi_write(24'h80, 0, 0, 4'hF, 1'b0, 1'b0, resp, bid);
        wbuf[0] = 32'hAABBCCDD;
        axi_write(24'h80, 0, 0, 4'b0101, 1'b1, 1'b0, resp, bid);
        chk("t3_bid", 32'(bid), 1);
        axi_read(24'h80, 0, 1'b1, 1'b0, lat, cyc);
        chk("t3_strb", rbuf[0], 32'h11BB33DD);

        // wrap from the last word to index 0, with random stalls
        wbuf[0] = 32'hA0A0A0A0; wbuf[1] = 32'hB1B1B1B1;
        axi_write(24'hFFC, 1, 1, 4'hF, 1'b0, 1'b1, resp, bid);
        chk("t4_bresp", 32'(resp), 0);
        axi_read(24'hFFC, 1, 1'b0, 1'b1, lat, cyc);
        chk("t4_d0", rbuf[0], 32'hA0A0A0A0);
        chk("t4_d1", rbuf[1], 32'hB1B1B1B1);
        axi_read(24'h0, 0, 1'b0, 1'b0, lat, cyc);
        chk("t4_idx0", rbuf[0], 32'hB1B1B1B1);
        axi_read(24'h1000, 0, 1'b0, 1'b0, lat, cyc);
        chk("t4_alias", rbuf[0], 32'hB1B1B1B1);

        // early wlast -> SLVERR, partial data kept
        wbuf[0] = 32'hD0; wbuf[1] = 32'hD1; wbuf[2] = 32'hD2; wbuf[3] = 32'hD3;
        axi_write(24'h100, 3, 3, 4'hF, 1'b0, 1'b0, resp, bid);
        wbuf[0] = 32'hC0; wbuf[1] = 32'hC1; wbuf[2] = 32'hC2; wbuf[3] = 32'hC3;
        axi_write(24'h100, 3, 1, 4'hF, 1'b1, 1'b0, resp, bid);
        chk("t5_slverr", 32'(resp), 2);
        chk("t5_bid", 32'(bid), 1);
        wbuf[0] = 32'h55;
        axi_write(24'h200, 0, 0, 4'hF, 1'b0, 1'b0, resp, bid);
        chk("t5_next_ok", 32'(resp), 0);
        // missing wlast at the final beat also flags SLVERR
        wbuf[0] = 32'h66; wbuf[1] = 32'h77;
        axi_write(24'h300, 1, 99, 4'hF, 1'b0, 1'b0, resp, bid);
        chk("t5_nolast", 32'(resp), 2);
        axi_read(24'h100, 3, 1'b0, 1'b0, lat, cyc);
        chk("t5_d0", rbuf[0], 32'hC0);
        chk("t5_d1", rbuf[1], 32'hC1);
        chk("t5_d2", rbuf[2], 32'hD2);
        chk("t5_d3", rbuf[3], 32'hD3);

        // reset in the middle of a read burst
        ar_send(24'h40, 3, 1'b1);
        axi_rready_i = 1'b0;
        repeat (5) tick();
        chk("t6_rvalid", 32'(axi_rvalid_o), 1);
        chk("t6_stall_d", axi_rdata_o, 32'h11);
        #3 rst_n_i = 1'b0;
        #1;
        chk("t6_async_rvalid", 32'(axi_rvalid_o), 0);
        chk("t6_async_arready", 32'(axi_arready_o), 0);
        tick();
        rst_n_i = 1'b1;
        chk("t6_rel_arready0", 32'(axi_arready_o), 0);
        tick();
        chk("t6_rel_arready1", 32'(axi_arready_o), 1);
        chk("t6_rel_rvalid", 32'(axi_rvalid_o), 0);
        axi_read(24'h40, 3, 1'b0, 1'b0, lat, cyc);
        chk("t6_keep0", rbuf[0], 32'h11);
        chk("t6_keep3", rbuf[3], 32'h44);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
